// File: rtl/encoder_scan_pkg.sv
// Shared constants and types for the 8-to-3 scanning encoder.
// Optional feature macro: ENC_POPCNT_EN (adds the cnt popcount port).
package enc_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDXW  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Number of set bits in a request vector.
  function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDXW:0] n;
    n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n = n + {{IDXW{1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/encoder_scan_lsb_encoder.sv
// Combinational lowest-set-bit encoder: index, one-hot mask of that bit,
// and a flag that is high when the vector has exactly one bit set.
module lsb_encoder
  import enc_pkg::*;
(
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  idx,
  output logic [WIDTH-1:0] mask,
  output logic             one_hot
);

  logic found;

  // Priority search from bit 0 upward; index is 0 for an all-zero vector.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[i] && !found) begin
        idx   = IDXW'(i);
        found = 1'b1;
      end
    end
  end

  // Isolate the lowest set bit and test for a single set bit.
  always_comb begin
    mask    = vec & (~vec + WIDTH'(1));
    one_hot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/encoder_scan.sv
// Sequential 8-to-3 scanning encoder: accepts a request vector, then emits
// the index of every set bit, lowest first, one beat per set bit.
// Optional feature macro: ENC_POPCNT_EN (cnt = popcount of accepted vector).
module encoder_scan
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [IDXW-1:0]  y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y_last,
  output logic             busy
`ifdef ENC_POPCNT_EN
  ,
  output logic [IDXW:0]    cnt
`endif
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pend;
  logic [IDXW-1:0]  lsb_idx;
  logic [WIDTH-1:0] lsb_mask;
  logic             lsb_one;
  logic             accept_nz;
  logic             beat_done;

  lsb_encoder u_lsb (
    .vec     (pend),
    .idx     (lsb_idx),
    .mask    (lsb_mask),
    .one_hot (lsb_one)
  );

  // Handshake qualifiers shared by state, pend and cnt updates.
  always_comb begin
    accept_nz = (state == IDLE) && d_valid && (d != '0);
    beat_done = (state == SCAN) && y_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: leave IDLE on a non-zero vector, leave SCAN on last beat.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept_nz)           state_next = SCAN;
      SCAN: if (y_ready && lsb_one)  state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // Pending-bit register: load on accept, drop the lowest bit on each beat.
  always_ff @(posedge clk) begin
    if (rst)            pend <= '0;
    else if (accept_nz) pend <= d;
    else if (beat_done) pend <= pend & ~lsb_mask;
  end

  // Outputs decode from state and pend only.
  always_comb begin
    d_ready = (state == IDLE);
    busy    = (state == SCAN);
    y_valid = (state == SCAN);
    y       = (state == SCAN) ? lsb_idx : '0;
    y_last  = (state == SCAN) && lsb_one;
  end

`ifdef ENC_POPCNT_EN
  // Popcount captured with each non-zero vector; zero vectors leave it alone.
  always_ff @(posedge clk) begin
    if (rst)            cnt <= '0;
    else if (accept_nz) cnt <= popcount(d);
  end
`endif

endmodule

// File: tb/tb_encoder_scan.sv
// Self-checking bench for encoder_scan: vector table, hand-written corner
// sequences and randomized vectors against a queue-based reference model.
module tb_encoder_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       d_valid;
  logic       d_ready;
  logic [2:0] y;
  logic       y_valid;
  logic       y_ready;
  logic       y_last;
  logic       busy;
`ifdef ENC_POPCNT_EN
  logic [3:0] cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_cnt = 0;

  encoder_scan dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_last  (y_last),
    .busy    (busy)
`ifdef ENC_POPCNT_EN
    ,
    .cnt     (cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] d;
    logic [2:0] y;
    logic       last;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_y_valid"}, y_valid, 0);
    chk({tag, "_d_ready"}, d_ready, 1);
    chk({tag, "_busy"},    busy,    0);
    chk({tag, "_y_last"},  y_last,  0);
    chk({tag, "_y"},       y,       0);
`ifdef ENC_POPCNT_EN
    chk({tag, "_cnt"},     cnt,     exp_cnt);
`endif
  endtask

  // Accept one vector, then drain it with y_ready high rdy_pct percent of the
  // time while d_valid/d toggle randomly (must be ignored during the scan).
  task automatic run_vector(input logic [7:0] v, input int unsigned rdy_pct, input string tag);
    int unsigned q[$];
    int unsigned guard;
    for (int i = 0; i < 8; i++) if (v[i]) q.push_back(i);
    chk({tag, "_accept_ready"}, d_ready, 1);
    d = v; d_valid = 1'b1; y_ready = 1'b0;
    step();
    d_valid = 1'b0;
    if (q.size() != 0) exp_cnt = q.size();
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      chk({tag, "_y_valid"}, y_valid, 1);
      chk({tag, "_y"},       y,       q[0]);
      chk({tag, "_y_last"},  y_last,  (q.size() == 1) ? 1 : 0);
      chk({tag, "_d_ready"}, d_ready, 0);
      chk({tag, "_busy"},    busy,    1);
`ifdef ENC_POPCNT_EN
      chk({tag, "_cnt"},     cnt,     exp_cnt);
`endif
      y_ready = ($urandom_range(99) < rdy_pct);
      d_valid = $urandom_range(1);
      d       = $urandom;
      step();
      if (y_ready) void'(q.pop_front());
      guard++;
    end
    if (guard >= 200) chk({tag, "_drain_timeout"}, guard, 0);
    d_valid = 1'b0; y_ready = 1'b0;
    chk_idle({tag, "_end"});
  endtask

  initial begin
    rst = 1'b1; d = '0; d_valid = 1'b0; y_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tbl[i].d    = 8'h01 << i;
      tbl[i].y    = 3'(i);
      tbl[i].last = 1'b1;
    end

    // Reset state
    step();
    exp_cnt = 0;
    chk_idle("reset");
    rst = 1'b0;
    step();

    // One-hot table: one beat each, with a busy d presented during the beat
    for (int i = 0; i < 8; i++) begin
      d = tbl[i].d; d_valid = 1'b1;
      step();
      exp_cnt = 1;
      d = 8'hFF;
      chk("tbl_y_valid", y_valid, 1);
      chk("tbl_y",       y,       tbl[i].y);
      chk("tbl_y_last",  y_last,  tbl[i].last);
      chk("tbl_d_ready", d_ready, 0);
      step();
      chk("tbl_busy_ignored", y_valid, 1);
      y_ready = 1'b1; d_valid = 1'b0;
      step();
      y_ready = 1'b0;
      chk_idle("tbl_end");
    end

    // Sparse vector with y_ready held high: 2, 5, 7 back to back
    run_vector(8'b1010_0100, 100, "sparse");

    // Backpressure: y=0 held 4 cycles, then 7 with last
    d = 8'h81; d_valid = 1'b1;
    step();
    d_valid = 1'b0; exp_cnt = 2;
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_valid", y_valid, 1);
      chk("bp_hold_y",     y,       0);
      chk("bp_hold_last",  y_last,  0);
      y_ready = (i == 3);
      step();
    end
    chk("bp_y7",      y,      7);
    chk("bp_y7_last", y_last, 1);
    step();
    y_ready = 1'b0;
    chk_idle("bp_end");

    // Zero vector (no beat, cnt unchanged) then full vector
    run_vector(8'h00, 100, "zero");
    run_vector(8'hFF, 100, "full");
`ifdef ENC_POPCNT_EN
    chk("full_cnt_hold", cnt, 8);
    run_vector(8'h00, 100, "zero2");
`endif

    // Reset mid-scan: first beat of 8'h07 taken, then reset
    d = 8'h07; d_valid = 1'b1;
    step();
    d_valid = 1'b0; y_ready = 1'b1;
    chk("rst_first_y", y, 0);
    step();
    chk("rst_second_y", y, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    chk_idle("rst_mid");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_beat", y_valid, 0);
    end
    y_ready = 1'b0;

    // Randomized vectors against the queue model
    for (int n = 0; n < 80; n++) begin
      logic [7:0] v;
      v = ($urandom_range(4) == 0) ? 8'h00 : 8'($urandom);
      run_vector(v, $urandom_range(100, 25), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
